echo_pipe_serializer: RTL and testbench
=======================================

# echo_pipe_serializer

Buffers 96-bit portal pipe messages (tag plus two 32-bit data words) and emits each one as three 32-bit beats on a narrow transport interface. It sits directly downstream of the request/indication "Output" proxy stages, which produce `pipe$enq` messages, and upstream of the word-wide transport feeding the matching "Input" proxy. Decoupling message production from transport back-pressure is done with a small message FIFO and a beat sequencer.

## Interface
Parameters:
- `DEPTH`, default 2: message FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- `CLK`  in  1  the single clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `in$enq__ENA`  in  1  message enqueue.
  - The caller asserts it only while `in$enq__RDY`=1.
  - Every cycle with ENA=1 is one accepted message.
- `in$enq$v`  in  96  the message.
  - [31:0] is the tag.
  - [63:32] is `meth`.
  - [95:64] is `v`.
- `in$enq__RDY`  out  1  FIFO not full.
- `out$enq__ENA`  out  1  beat transfer. Equals `!empty & out$enq__RDY`.
- `out$enq$v`  out  32  current beat word.
- `out$enq$last`  out  1  high on the third beat of a message.
- `out$enq__RDY`  in  1  the transport can take a beat this cycle.

## Operation
- **Storage**
  - `DEPTH` × 96-bit array.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count, 0..DEPTH.
  - 2-bit beat counter `beat`, values 0..2.
- **Enqueue:** when `in$enq__ENA`=1, write `in$enq$v` at the write pointer, then wptr+1 and count+1.
- **Beat mux** (from the head entry):
  - beat=0 → tag [31:0].
  - beat=1 → `meth` [63:32].
  - beat=2 → `v` [95:64].
- `out$enq$last` = (beat==2) & !empty.
- **Beat transfer:** a transfer occurs when `out$enq__ENA`=1.
  - beat<2: beat+1.
  - beat==2: beat←0, rptr+1, count−1 (pop).
- **Simultaneous enqueue and pop in one cycle:** count is unchanged, and both pointers advance.
- **Full:** `in$enq__RDY`=0 when count==DEPTH.
  - RDY is derived from the registered count only.
  - A pop in the same cycle does not raise RDY; there is no full-bypass.
- **Empty:** `out$enq__ENA`=0 and `out$enq$last`=0.
  - `out$enq$v` is undefined and must not be checked.
  - There is no empty-bypass: a message written into an empty FIFO is not visible on the output in the same cycle.
- **Message order:** messages are emitted strictly in arrival order, with no reordering and no drop.
- **Tag:** the tag value is not interpreted; tag 0 is passed through like any other.
- **Beat-counter reset point:** beat returns to 0 only on a pop or on reset, never while a message is partially sent.
- **Reset (asynchronous assertion):**
  - Pointers, count and beat are cleared.
  - While `RST`=1: `in$enq__RDY`=0, `out$enq__ENA`=0, `out$enq$last`=0.
  - A message partially serialized when reset asserts is discarded, and its remaining beats are never emitted.
  - Array contents are not reset.
- **Reset release:** on the first rising edge after deassertion, `in$enq__RDY`=1.

## Timing
- Enqueue in cycle N into an empty FIFO → beat 0 offered in cycle N+1 (`out$enq__ENA`=1 if `out$enq__RDY`=1).
- With `out$enq__RDY` held at 1, beats 0, 1 and 2 go out in cycles N+1, N+2 and N+3.
  - `out$enq$last`=1 in N+3.
  - The next message's beat 0 follows in N+4, with no bubble between messages.
- Sustained output rate: 1 message per 3 cycles. Input back-pressures once DEPTH messages are resident.
- When `out$enq__RDY` drops mid-message:
  - beat and the output word hold.
  - The sequence resumes at the same beat when RDY returns.
- `in$enq__RDY` falls in the cycle after the enqueue that fills the FIFO. It rises in the cycle after the pop that frees an entry.

## Test plan
- **Reset and idle:** assert `RST`, then release.
  - During reset: RDY=0 and ENA=0.
  - After the first edge: `in$enq__RDY`=1, `out$enq__ENA`=0.
- **Single message:** enqueue tag=1, meth=0x0000_0005, v=0xDEAD_BEEF with `out$enq__RDY`=1.
  - Beats come out in the next 3 cycles: 0x1, 0x5, 0xDEADBEEF.
  - `last` is high only on the third beat.
- **Fill and back-pressure** (DEPTH=2), with `out$enq__RDY`=0:
  - Enqueue 2 messages → `in$enq__RDY`=0, and no beats are emitted.
  - Raise `out$enq__RDY` → after the third beat, `in$enq__RDY` returns to 1 the following cycle.
- **Stall mid-message:** drop `out$enq__RDY` after beat 1 for 5 cycles.
  - `out$enq$v` holds `meth`, and ENA=0 throughout the stall.
  - On resume: `meth` then `v`, with no repeated or skipped beat.
- **Simultaneous enqueue and pop** at count=1: enqueue in the same cycle as beat 2 of the head message.
  - Count stays at 1.
  - The new message's beat 0 follows in the next cycle.
  - 10 back-to-back messages with incrementing tags emerge in order.
- **Reset mid-message:** assert `RST` after beat 0 with 2 messages queued.
  - Both messages are discarded.
  - After release, a new message emits beat 0 first, with the correct tag.

Source files
------------

// File: rtl/echo_pipe_serializer.sv
`default_nettype none
// ============================================================================
// Module   : echo_pipe_serializer
// Purpose  : Buffers 96-bit pipe messages and emits each as three 32-bit beats.
// Revision : 1.0  initial release
// ============================================================================
module echo_pipe_serializer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_in_enq_ena,
    input  logic [95:0] i_in_enq_v,
    output logic        o_in_enq_rdy,
    output logic        o_out_enq_ena,
    output logic [31:0] o_out_enq_v,
    output logic        o_out_enq_last,
    input  logic        i_out_enq_rdy
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL      = DEPTH[c_AW:0];
    localparam logic [1:0]      c_LAST_BEAT = 2'd2;

    logic [95:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_beat;
    logic            r_live;

    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [95:0]     w_head;

    assign w_empty        = (r_count == '0);
    // r_live keeps RDY low through reset until the first edge after release.
    assign o_in_enq_rdy   = r_live & (r_count != c_FULL);
    assign o_out_enq_ena  = ~w_empty & i_out_enq_rdy;
    assign o_out_enq_last = ~w_empty & (r_beat == c_LAST_BEAT);
    assign w_push         = i_in_enq_ena & o_in_enq_rdy;
    assign w_pop          = o_out_enq_ena & (r_beat == c_LAST_BEAT);
    assign w_head         = r_mem[r_rptr];

    always_comb begin
        o_out_enq_v = w_head[31:0];
        case (r_beat)
            2'd1:    o_out_enq_v = w_head[63:32];
            2'd2:    o_out_enq_v = w_head[95:64];
            default: o_out_enq_v = w_head[31:0];
        endcase
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_in_enq_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (o_out_enq_ena) begin
                if (r_beat == c_LAST_BEAT) begin
                    r_beat <= '0;
                    r_rptr <= r_rptr + c_AW'(1);
                end else begin
                    r_beat <= r_beat + 2'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_pipe_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_echo_pipe_serializer
// Purpose  : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0  initial release
// ============================================================================
module tb_echo_pipe_serializer;

    localparam int DEPTH = 2;

    logic        CLK;
    logic        RST;
    logic        enq_i;
    logic [95:0] msg_i;
    logic        ordy_i;
    logic        in_rdy_o;
    logic        out_ena_o;
    logic [31:0] out_v_o;
    logic        out_last_o;

    echo_pipe_serializer #(.DEPTH(DEPTH)) dut (
        .clk            (CLK),
        .rst            (RST),
        .i_in_enq_ena   (enq_i),
        .i_in_enq_v     (msg_i),
        .o_in_enq_rdy   (in_rdy_o),
        .o_out_enq_ena  (out_ena_o),
        .o_out_enq_v    (out_v_o),
        .o_out_enq_last (out_last_o),
        .i_out_enq_rdy  (ordy_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of whole messages plus index of the next beat.
    logic [95:0] mq[$];
    int          mbeat  = 0;
    bit          mlive  = 0;
    int          n_popped = 0;

    logic        s_rdy, s_ena, s_last;
    logic [31:0] s_v;

    typedef struct {
        bit          enq;
        logic [95:0] msg;
        bit          ordy;
        bit          x_rdy;
        bit          x_ena;
        bit          x_last;
        bit          chk_v;
        logic [31:0] x_v;
    } vec_t;

    vec_t tv[15];

    function automatic logic [95:0] mk(input logic [31:0] tag, input logic [31:0] meth,
                                       input logic [31:0] v);
        return {v, meth, tag};
    endfunction

    function automatic logic [31:0] word_of(input logic [95:0] m, input int b);
        if (b == 0) return m[31:0];
        else if (b == 1) return m[63:32];
        else return m[95:64];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit enq, input logic [95:0] msg, input bit ordy);
        bit          e_rdy, e_ena, e_last, do_enq;
        logic [31:0] e_v;
        e_rdy  = mlive && (mq.size() < DEPTH);
        e_ena  = (mq.size() > 0) && ordy;
        e_last = (mq.size() > 0) && (mbeat == 2);
        e_v    = '0;
        if (mq.size() > 0) e_v = word_of(mq[0], mbeat);
        do_enq = enq && e_rdy;
        enq_i  = do_enq;
        msg_i  = msg;
        ordy_i = ordy;
        @(negedge CLK);
        s_rdy  = in_rdy_o;
        s_ena  = out_ena_o;
        s_last = out_last_o;
        s_v    = out_v_o;
        chk("model_in_rdy", {31'b0, s_rdy}, {31'b0, e_rdy});
        chk("model_out_ena", {31'b0, s_ena}, {31'b0, e_ena});
        chk("model_last", {31'b0, s_last}, {31'b0, e_last});
        if (mq.size() > 0) chk("model_word", s_v, e_v);
        @(posedge CLK);
        if (e_ena) begin
            mbeat++;
            if (mbeat == 3) begin
                void'(mq.pop_front());
                mbeat = 0;
                n_popped++;
            end
        end
        if (do_enq) mq.push_back(msg);
        mlive = 1;
        #1;
    endtask

    logic [95:0] M1, M2, M3, M4, M5, M6, MA, MB, MC;

    initial begin
        M1 = mk(32'h1, 32'h0000_0005, 32'hDEAD_BEEF);
        M2 = mk(32'h2222_0000, 32'h2222_0001, 32'h2222_0002);
        M3 = mk(32'h3333_0000, 32'h3333_0001, 32'h3333_0002);
        M4 = mk(32'h4444_0000, 32'h4444_0001, 32'h4444_0002);
        M5 = mk(32'h5555_0000, 32'h5555_0001, 32'h5555_0002);
        M6 = mk(32'h6666_0000, 32'h6666_0001, 32'h6666_0002);
        MA = mk(32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002);
        MB = mk(32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0002);
        MC = mk(32'h0000_0000, 32'hCCCC_0001, 32'hCCCC_0002);

        //        enq msg ordy rdy ena last chk_v word
        tv[0]  = '{1, M1, 1, 1, 0, 0, 0, 32'h0};
        tv[1]  = '{0, 96'h0, 1, 1, 1, 0, 1, 32'h1};
        tv[2]  = '{0, 96'h0, 1, 1, 1, 0, 1, 32'h5};
        tv[3]  = '{0, 96'h0, 1, 1, 1, 1, 1, 32'hDEAD_BEEF};
        tv[4]  = '{0, 96'h0, 1, 1, 0, 0, 0, 32'h0};
        tv[5]  = '{1, M2, 0, 1, 0, 0, 0, 32'h0};
        tv[6]  = '{1, M3, 0, 1, 0, 0, 1, 32'h2222_0000};
        tv[7]  = '{0, 96'h0, 0, 0, 0, 0, 1, 32'h2222_0000};
        tv[8]  = '{0, 96'h0, 1, 0, 1, 0, 1, 32'h2222_0000};
        tv[9]  = '{0, 96'h0, 1, 0, 1, 0, 1, 32'h2222_0001};
        tv[10] = '{0, 96'h0, 1, 0, 1, 1, 1, 32'h2222_0002};
        tv[11] = '{0, 96'h0, 1, 1, 1, 0, 1, 32'h3333_0000};
        tv[12] = '{0, 96'h0, 1, 1, 1, 0, 1, 32'h3333_0001};
        tv[13] = '{0, 96'h0, 1, 1, 1, 1, 1, 32'h3333_0002};
        tv[14] = '{0, 96'h0, 1, 1, 0, 0, 0, 32'h0};

        // Reset and idle
        RST = 1'b1; enq_i = 1'b0; msg_i = '0; ordy_i = 1'b1;
        #12;
        chk("rst_in_rdy", {31'b0, in_rdy_o}, 32'h0);
        chk("rst_out_ena", {31'b0, out_ena_o}, 32'h0);
        chk("rst_last", {31'b0, out_last_o}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        mlive = 1;

        // Table-driven: single message, then fill/back-pressure/drain
        for (int i = 0; i < 15; i++) begin
            step(tv[i].enq, tv[i].msg, tv[i].ordy);
            chk($sformatf("tv%0d_in_rdy", i), {31'b0, s_rdy}, {31'b0, tv[i].x_rdy});
            chk($sformatf("tv%0d_ena", i), {31'b0, s_ena}, {31'b0, tv[i].x_ena});
            chk($sformatf("tv%0d_last", i), {31'b0, s_last}, {31'b0, tv[i].x_last});
            if (tv[i].chk_v) chk($sformatf("tv%0d_word", i), s_v, tv[i].x_v);
        end

        // Stall after beat 0 for 5 cycles while meth is offered
        step(1, M4, 1);
        step(0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 0);
            chk("stall_word", s_v, 32'h4444_0001);
            chk("stall_ena", {31'b0, s_ena}, 32'h0);
        end
        step(0, '0, 1);
        chk("resume_meth", s_v, 32'h4444_0001);
        step(0, '0, 1);
        chk("resume_v", s_v, 32'h4444_0002);
        chk("resume_last", {31'b0, s_last}, 32'h1);

        // Enqueue on the same cycle as the pop at count 1
        step(1, M5, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        step(1, M6, 1);
        step(0, '0, 1);
        chk("simul_word", s_v, 32'h6666_0000);
        chk("simul_ena", {31'b0, s_ena}, 32'h1);
        chk("simul_in_rdy", {31'b0, s_rdy}, 32'h1);

        // 10 back-to-back messages with incrementing tags
        begin
            int tagc = 0;
            n_popped = 0;
            for (int c = 0; c < 60 && tagc < 10; c++) begin
                if (mq.size() < DEPTH) begin
                    step(1, mk(32'h100 + tagc, 32'h200 + tagc, 32'h300 + tagc), 1);
                    tagc++;
                end else begin
                    step(0, '0, 1);
                end
            end
            for (int c = 0; c < 12; c++) step(0, '0, 1);
            chk("b2b_msgs_out", n_popped, 11);
        end

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [95:0] r;
            r = {$urandom, $urandom, (($urandom % 8) == 0) ? 32'h0 : $urandom};
            step(($urandom % 2) == 0, r, ($urandom % 4) != 0);
        end
        for (int c = 0; c < 10; c++) step(0, '0, 1);

        // Reset after beat 0 with two messages queued
        step(1, MA, 0);
        step(1, MB, 0);
        step(0, '0, 1);
        #2 RST = 1'b1;
        #1;
        chk("rstmid_in_rdy", {31'b0, in_rdy_o}, 32'h0);
        chk("rstmid_ena", {31'b0, out_ena_o}, 32'h0);
        chk("rstmid_last", {31'b0, out_last_o}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        chk("rsthold_in_rdy", {31'b0, in_rdy_o}, 32'h0);
        chk("rsthold_ena", {31'b0, out_ena_o}, 32'h0);
        RST = 1'b0;
        mq.delete();
        mbeat = 0;
        mlive = 0;
        @(posedge CLK); #1;
        mlive = 1;
        step(1, MC, 1);
        chk("postrst_in_rdy", {31'b0, s_rdy}, 32'h1);
        step(0, '0, 1);
        chk("postrst_tag", s_v, 32'h0);
        chk("postrst_ena", {31'b0, s_ena}, 32'h1);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("postrst_v", s_v, 32'hCCCC_0002);
        step(0, '0, 1);
        chk("postrst_empty", {31'b0, s_ena}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
